// File: rtl/load_extract_unit_pkg.sv
// Shared definitions for the load extract unit.
//   - RV64I load funct3 encodings
//   - FSM state type
//   - default address width
package load_extract_unit_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 64;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;
    localparam logic [2:0] FUNCT3_ILL = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/load_lane_extend.sv
// Combinational lane select and sign/zero extension for RV64I loads.
// Ports:
//   rdata    in  64  doubleword read from memory, little-endian
//   offset   in  3   byte offset within the doubleword
//   funct3   in  3   load type
//   ext      out 64  selected lane, extended to 64 bits
//   misalign out 1   offset is not naturally aligned for the access size
module load_lane_extend
    import load_extract_unit_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] ext,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_w;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = rdata[{offset[2:1], 4'b0000} +: 16];
        lane_w = rdata[{offset[2], 5'b00000} +: 32];
    end

    always_comb begin
        ext      = '0;
        misalign = 1'b0;
        case (funct3)
            FUNCT3_LB:  ext = {{56{lane_b[7]}}, lane_b};
            FUNCT3_LBU: ext = {56'd0, lane_b};
            FUNCT3_LH: begin
                ext      = {{48{lane_h[15]}}, lane_h};
                misalign = offset[0];
            end
            FUNCT3_LHU: begin
                ext      = {48'd0, lane_h};
                misalign = offset[0];
            end
            FUNCT3_LW: begin
                ext      = {{32{lane_w[31]}}, lane_w};
                misalign = |offset[1:0];
            end
            FUNCT3_LWU: begin
                ext      = {32'd0, lane_w};
                misalign = |offset[1:0];
            end
            FUNCT3_LD: begin
                ext      = rdata;
                misalign = |offset;
            end
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/load_extract_unit.sv
// RV64I load unit: issues a doubleword-aligned read, waits for a
// variable-latency response, extracts and extends the addressed lane.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, funct3, addr load request (sampled only when idle)
//   mem_req, mem_addr   one-cycle read strobe and aligned address
//   mem_rdata, mem_rvalid  read response
//   busy, done, err     status; err is valid with the done pulse
//   load_data           extended result, held until the next done
// TIMEOUT must lie in 2..255 (counter is 8 bits).
module load_extract_unit
    import load_extract_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [63:0]       load_data
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [63:0]       data_q, data_d;
    logic              err_q, err_d;

    logic [2:0]        ext_off;
    logic [2:0]        ext_f3;
    logic [63:0]       ext_data;
    logic              ext_misalign;

    // The extender checks alignment of the incoming request while idle and
    // extracts the response lane using the latched request otherwise.
    always_comb begin
        ext_off = (state_q == StIdle) ? addr[2:0] : off_q;
        ext_f3  = (state_q == StIdle) ? funct3    : f3_q;
    end

    load_lane_extend u_lane_extend (
        .rdata    (mem_rdata),
        .offset   (ext_off),
        .funct3   (ext_f3),
        .ext      (ext_data),
        .misalign (ext_misalign)
    );

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if ((funct3 == FUNCT3_ILL) || ext_misalign) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = StDone;
                    end else begin
                        f3_d    = funct3;
                        off_d   = addr[2:0];
                        addr_d  = {addr[ADDR_W-1:3], 3'b000};
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mem_rvalid) begin
                    data_d  = ext_data;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_req   = (state_q == StReq);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_addr  = addr_q;
        err       = err_q;
        load_data = data_q;
    end

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed self-checking bench for load_extract_unit.
module tb_load_extract_unit;
    import load_extract_unit_pkg::*;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [63:0] RDATA = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] load_data;

    int checks = 0;
    int errors = 0;

    load_extract_unit #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .funct3     (funct3),
        .addr       (addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and a memory response rv_delay cycles after the
    // first WAIT cycle (negative: never). Returns observations only.
    task automatic run_load(input logic [2:0] f3, input logic [63:0] a, input int rv_delay,
                            input bit poke, output int lat, output logic [63:0] data,
                            output logic e, output bit saw_req, output logic [63:0] maddr,
                            output logic done_after, output logic busy_after);
        int req_cycle;
        bit got;
        req_cycle = -100;
        got       = 1'b0;
        lat       = -1;
        data      = '0;
        e         = 1'b0;
        saw_req   = 1'b0;
        maddr     = '0;
        funct3    = f3;
        addr      = a;
        mem_rdata = RDATA;
        start     = 1'b1;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (poke && c == 3) begin
                start  = 1'b1;
                funct3 = FUNCT3_ILL;
                addr   = a + 64'd1;
            end
            if (mem_req === 1'b1) begin
                if (!saw_req) req_cycle = c;
                saw_req = 1'b1;
                maddr   = mem_addr;
            end
            if (done === 1'b1) begin
                got  = 1'b1;
                lat  = c;
                data = load_data;
                e    = err;
            end
            mem_rvalid = (rv_delay >= 0 && saw_req && c == req_cycle + 1 + rv_delay);
        end
        start      = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        funct3     = 3'b000;
        addr       = '0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        #12;
        checks++;
        if ({mem_req, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {mem_req, busy, done, err});
        end
        checks++;
        if (mem_addr !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if (load_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_load_data: got %h expected 0", load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_byte_loads();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LB, BASE + 64'd7, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFE || e !== 1'b0) begin
            errors++;
            $display("FAIL lb_data: got %h err %b expected FFFFFFFFFFFFFFFE err 0", d, e);
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL lb_latency: got %0d expected 3", lat);
        end
        checks++;
        if (ma !== BASE) begin
            errors++;
            $display("FAIL lb_mem_addr: got %h expected %h", ma, BASE);
        end
        checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL lb_done_pulse: got done %b busy %b expected 0 0", da, ba);
        end
        run_load(FUNCT3_LBU, BASE + 64'd7, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_0000_00FE || e !== 1'b0) begin
            errors++;
            $display("FAIL lbu_data: got %h err %b expected 00000000000000FE err 0", d, e);
        end
        run_load(FUNCT3_LB, BASE + 64'd1, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_0000_0032) begin
            errors++;
            $display("FAIL lb_positive: got %h expected 0000000000000032", d);
        end
    endtask

    task automatic test_half_word_loads();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LH, BASE + 64'd6, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FEDC) begin
            errors++;
            $display("FAIL lh_data: got %h expected FFFFFFFFFFFFFEDC", d);
        end
        run_load(FUNCT3_LHU, BASE + 64'd2, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_0000_7654) begin
            errors++;
            $display("FAIL lhu_data: got %h expected 0000000000007654", d);
        end
        run_load(FUNCT3_LWU, BASE + 64'd4, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_FEDC_BA98) begin
            errors++;
            $display("FAIL lwu_data: got %h expected 00000000FEDCBA98", d);
        end
        run_load(FUNCT3_LW, BASE + 64'd4, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'hFFFF_FFFF_FEDC_BA98) begin
            errors++;
            $display("FAIL lw_signed: got %h expected FFFFFFFFFEDCBA98", d);
        end
        run_load(FUNCT3_LW, BASE, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_7654_3210) begin
            errors++;
            $display("FAIL lw_data: got %h expected 0000000076543210", d);
        end
        run_load(FUNCT3_LD, BASE + 64'd8, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== RDATA || ma !== BASE + 64'd8) begin
            errors++;
            $display("FAIL ld_data: got %h addr %h expected %h addr %h", d, ma, RDATA,
                     BASE + 64'd8);
        end
    endtask

    task automatic test_misaligned_illegal();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LW, BASE + 64'd2, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 1 || e !== 1'b1 || d !== 64'd0 || rq) begin
            errors++;
            $display("FAIL lw_misaligned: got lat %0d err %b data %h req %0d expected 1 1 0 0",
                     lat, e, d, rq);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err %b busy %b expected 0 0", err, busy);
        end
        run_load(FUNCT3_LH, BASE + 64'd3, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 1 || e !== 1'b1 || rq) begin
            errors++;
            $display("FAIL lh_misaligned: got lat %0d err %b req %0d expected 1 1 0", lat, e, rq);
        end
        run_load(FUNCT3_LD, BASE + 64'd4, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 1 || e !== 1'b1 || rq) begin
            errors++;
            $display("FAIL ld_misaligned: got lat %0d err %b req %0d expected 1 1 0", lat, e, rq);
        end
        run_load(FUNCT3_ILL, BASE, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 1 || e !== 1'b1 || d !== 64'd0 || rq) begin
            errors++;
            $display("FAIL illegal: got lat %0d err %b data %h req %0d expected 1 1 0 0",
                     lat, e, d, rq);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LHU, BASE + 64'd6, 5, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 8 || d !== 64'h0000_0000_0000_FEDC || e !== 1'b0) begin
            errors++;
            $display("FAIL wait5: got lat %0d data %h err %b expected 8 000000000000FEDC 0",
                     lat, d, e);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LD, BASE, -1, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 2 + int'(TIMEOUT) || e !== 1'b1 || d !== 64'd0) begin
            errors++;
            $display("FAIL timeout: got lat %0d err %b data %h expected %0d 1 0",
                     lat, e, d, 2 + TIMEOUT);
        end
    endtask

    task automatic test_start_while_busy();
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        run_load(FUNCT3_LB, BASE + 64'd5, 4, 1'b1, lat, d, e, rq, ma, da, ba);
        checks++;
        if (lat != 7 || d !== 64'hFFFF_FFFF_FFFF_FFBA || e !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: got lat %0d data %h err %b expected 7 FFFFFFFFFFFFFFBA 0",
                     lat, d, e);
        end
        checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got done %b busy %b expected 0 0", da, ba);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        int lat; logic [63:0] d; logic e; bit rq; logic [63:0] ma; logic da, ba;
        funct3    = FUNCT3_LD;
        addr      = BASE + 64'd16;
        mem_rdata = RDATA;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_addr !== BASE + 64'd16) begin
            errors++;
            $display("FAIL mid_wait_busy: got busy %b addr %h expected 1 %h", busy, mem_addr,
                     BASE + 64'd16);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, done, err} !== 4'b0000 || mem_addr !== 64'd0 ||
            load_data !== 64'd0) begin
            errors++;
            $display("FAIL mid_wait_reset: got flags %b addr %h data %h expected 0",
                     {mem_req, busy, done, err}, mem_addr, load_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL late_rvalid: got %0d active cycles expected 0", seen);
        end
        run_load(FUNCT3_LBU, BASE + 64'd3, 0, 1'b0, lat, d, e, rq, ma, da, ba);
        checks++;
        if (d !== 64'h0000_0000_0000_0076 || lat != 3) begin
            errors++;
            $display("FAIL after_reset: got data %h lat %0d expected 0000000000000076 3", d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_half_word_loads();
        test_misaligned_illegal();
        test_wait_states();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_extract_unit.md
Name: load_extract_unit

Overview:
- Read-side counterpart of the store-merge path: performs RV64I loads (LB/LH/LW/LD/LBU/LHU/LWU) against the 64-bit data memory.
- Issues a doubleword-aligned read request and waits for a variable-latency response.
- Selects the addressed byte lane, sign- or zero-extends the value, and returns a registered 64-bit result with a one-cycle done pulse.
- Sits between the multicycle control unit and the data memory port; its result feeds the register-file write-back mux.

Parameters:
- TIMEOUT, 16, maximum WAIT-state cycles before the load aborts with err (legal range 2..255).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request from control; sampled only in IDLE.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- addr  in  ADDR_W  effective byte address.
- mem_req  out  1  read strobe to data memory.
- mem_addr  out  ADDR_W  doubleword-aligned read address, {addr[63:3],3'b000}.
- mem_rdata  in  64  read data, little-endian.
- mem_rvalid  in  1  read data valid.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done on misaligned, illegal, or timed-out loads.
- load_data  out  64  extended result; holds its value until the next done.

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_req=0, mem_addr=0, busy=0, done=0, err=0, load_data=0; timeout counter=0.
- Only one clock domain. All outputs are registered or decoded from state (Moore).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, start=1, access is misaligned or funct3=111:
  - Misaligned means LH/LHU with addr[0]!=0, LW/LWU with addr[1:0]!=0, or LD with addr[2:0]!=0.
  - Go to DONE with err=1 and load_data=0.
  - No mem_req is issued.
- IDLE, start=1, access is legal: latch funct3 and addr[2:0], drive mem_addr, go to REQ.
- REQ: mem_req=1 for exactly one cycle, then WAIT. Clear the counter.
- WAIT:
  - mem_rvalid=1: load_data <= extend(lane), err <= 0, go to DONE.
  - mem_rvalid=0 and counter==TIMEOUT-1: err <= 1, load_data <= 0, go to DONE.
  - Otherwise increment the counter.
- DONE: done=1 for one cycle, then IDLE. The err value from the transition out of IDLE/WAIT is visible in this cycle. err returns to 0 on entry to IDLE.
- mem_rvalid outside WAIT is ignored.
- start is ignored while busy=1.
- Lane select (little-endian):
  - byte = rdata[8*a+7 : 8*a]
  - half = rdata[16*a[2:1]+15 : 16*a[2:1]]
  - word = rdata[32*a[2]+31 : 32*a[2]]
  - a = latched addr[2:0].
- Extension: LB/LH/LW replicate the MSB of the selected lane. LBU/LHU/LWU zero-fill. LD passes all 64 bits.
- Latency: start accepted at cycle 0 → mem_req in cycle 1 → earliest rvalid in cycle 2 → done in cycle 3. A zero-wait load therefore takes 4 cycles from start to the next acceptable start.
- Error latency: start in cycle 0 → done with err in cycle 1.
- rst_n asserted mid-operation: immediate return to reset values. An in-flight memory response that arrives after reset is ignored.

Decomposition:
- Shared package: load funct3 constants (FUNCT3_LB … FUNCT3_LWU), FSM state enum, and the ADDR_W default.
- Sub-module load_lane_extend (purely combinational): inputs rdata, offset, funct3; output extended 64-bit value plus a misalign flag.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Signed and unsigned byte loads. mem_rdata=64'hFEDC_BA98_7654_3210, no wait state.
  - LB addr=...07 → load_data=64'hFFFF_FFFF_FFFF_FFFE, err=0, done 3 cycles after start.
  - LBU at the same address → 64'h0000_0000_0000_00FE.
- Half and word loads, same mem_rdata.
  - LH addr=...06 → 64'hFFFF_FFFF_FFFF_FEDC.
  - LWU addr=...04 → 64'h0000_0000_FEDC_BA98.
  - LW addr=...00 → 64'h0000_0000_7654_3210.
  - LD addr=...08 → mem_addr=...08, load_data=64'hFEDC_BA98_7654_3210.
- Misaligned and illegal requests.
  - LW addr=...02 → done+err one cycle after start, load_data=0, mem_req never asserted.
  - funct3=111 → same response.
- Wait states and timeout.
  - rvalid delayed 5 cycles → correct data, done 1 cycle after rvalid.
  - rvalid never arrives → done+err exactly TIMEOUT cycles after entering WAIT.
  - A start pulsed while busy is ignored.
- Reset mid-WAIT.
  - Drop rst_n in WAIT, then raise it.
  - All outputs return to 0, state IDLE.
  - A late mem_rvalid does not produce done.
